// File: rtl/inv_check_pkg.sv
// inv_check_pkg: shared widths, fixed-point one, FSM states and 3x3 matrix type for the inverse checker
package inv_check_pkg;
    localparam int DW_DEF   = 32;
    localparam int FRAC_DEF = 16;
    localparam logic [DW_DEF-1:0] ONE = DW_DEF'(1) << FRAC_DEF;
    typedef enum logic [1:0] {IDLE, MAC, CHECK, DONE} state_t;
    typedef logic [2:0][2:0][DW_DEF-1:0] mat3_t;
endpackage

// File: rtl/inv_check_mac_if.sv
// inv_check_mac_if: matrix inputs, strobes and result/status bus of the inverse checker
interface inv_check_mac_if #(parameter int DW = inv_check_pkg::DW_DEF);
    logic [DW-1:0] a, b, c, d, e, f, g, h, i;
    logic a_valid, inv_valid;
    logic [2:0][2:0][DW-1:0] A_inv, P;
    logic pass, done, busy, overrun;
`ifdef INV_CHECK_MAXERR_EN
    logic [DW-1:0] max_err;
`endif
    modport master (
        output a, b, c, d, e, f, g, h, i, a_valid, A_inv, inv_valid,
        input  P, pass, done, busy, overrun
`ifdef INV_CHECK_MAXERR_EN
        , max_err
`endif
    );
    modport slave (
        input  a, b, c, d, e, f, g, h, i, a_valid, A_inv, inv_valid,
        output P, pass, done, busy, overrun
`ifdef INV_CHECK_MAXERR_EN
        , max_err
`endif
    );
endinterface

// File: rtl/inv_check_mac_fx_mac.sv
// fx_mac: registered signed multiply, 2*DW+2 accumulate, floor shift by FRAC and DW saturation
module fx_mac #(
    parameter int DW   = 32,
    parameter int FRAC = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue,
    input  logic                 first,
    input  logic                 last,
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] y,
    output logic                 out_v,
    output logic        [DW-1:0] res
);
    localparam int PW = 2 * DW;
    localparam int AW = 2 * DW + 2;
    localparam logic signed [AW-1:0] MAXV = (AW'(1) << (DW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;
    logic signed [PW-1:0] p_q, p_d;
    logic signed [AW-1:0] acc_q, acc_d, sh;
    logic v_q, v_d, first_q, first_d, last_q, last_d;
    always_comb begin
        p_d     = issue ? x * y : p_q;
        v_d     = issue;
        first_d = first;
        last_d  = last;
        acc_d   = v_q ? (first_q ? AW'(p_q) : acc_q + AW'(p_q)) : acc_q;
        sh      = acc_d >>> FRAC;
        out_v   = v_q & last_q;
        res     = (sh > MAXV) ? MAXV[DW-1:0] : (sh < MINV) ? MINV[DW-1:0] : sh[DW-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q     <= '0;
            acc_q   <= '0;
            v_q     <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            p_q     <= p_d;
            acc_q   <= acc_d;
            v_q     <= v_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: rtl/inv_check_mac.sv
// inv_check_mac: computes A x A_inv with one shared MAC and checks it against identity; INV_CHECK_MAXERR_EN adds max_err
module inv_check_mac
    import inv_check_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int TOL  = 655
) (
    input logic            clk,
    input logic            rst_n,
    inv_check_mac_if.slave bus
);
    localparam int EW = DW + 2;
    localparam logic signed [EW-1:0] ONE_E = EW'(1) << FRAC;
    localparam logic [EW-1:0] TOL_E = EW'(TOL);
    typedef logic [2:0][2:0][DW-1:0] mat_t;
    state_t state_q, state_d;
    mat_t a_q, a_d, ai_q, ai_d, p_q, p_d;
    logic pass_q, pass_d, ovr_q, ovr_d, drain_q, drain_d;
    logic [1:0] ci_q, ci_d, cj_q, cj_d, ck_q, ck_d, wi_q, wi_d, wj_q, wj_d;
    logic busy, issue, mac_v, all_ok;
    logic [DW-1:0] mac_res;
    logic signed [EW-1:0] df;
    logic [EW-1:0] ad;
`ifdef INV_CHECK_MAXERR_EN
    localparam logic [EW-1:0] MAXE = (EW'(1) << (DW - 1)) - EW'(1);
    logic [EW-1:0] merr;
    logic [DW-1:0] maxerr_q, maxerr_d;
`endif
    assign busy = state_q != IDLE;
    fx_mac #(.DW(DW), .FRAC(FRAC)) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .issue(issue),
        .first(ck_q == 2'd0),
        .last (ck_q == 2'd2),
        .x    (a_q[ci_q][ck_q]),
        .y    (ai_q[ck_q][cj_q]),
        .out_v(mac_v),
        .res  (mac_res)
    );
    always_comb begin
        all_ok = 1'b1;
        df     = '0;
        ad     = '0;
`ifdef INV_CHECK_MAXERR_EN
        merr   = '0;
`endif
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                df     = $signed({{2{p_q[r][c][DW-1]}}, p_q[r][c]}) - ((r == c) ? ONE_E : '0);
                ad     = df[EW-1] ? -df : df;
                all_ok = all_ok & (ad <= TOL_E);
`ifdef INV_CHECK_MAXERR_EN
                merr   = (ad > merr) ? ad : merr;
`endif
            end
        end
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        ai_d    = ai_q;
        p_d     = p_q;
        pass_d  = pass_q;
        ovr_d   = ovr_q | (busy & (bus.a_valid | bus.inv_valid));
        drain_d = drain_q;
        ci_d    = ci_q;
        cj_d    = cj_q;
        ck_d    = ck_q;
        wi_d    = wi_q;
        wj_d    = wj_q;
        issue   = 1'b0;
`ifdef INV_CHECK_MAXERR_EN
        maxerr_d = maxerr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.a_valid)
                    a_d = {bus.i, bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
                if (bus.inv_valid) begin
                    ai_d    = bus.A_inv;
                    state_d = MAC;
                    pass_d  = 1'b0;
                    drain_d = 1'b0;
                    ci_d    = 2'd0;
                    cj_d    = 2'd0;
                    ck_d    = 2'd0;
                end
            end
            MAC: begin
                issue = !drain_q;
                if (issue) begin
                    wi_d    = ci_q;
                    wj_d    = cj_q;
                    ck_d    = (ck_q == 2'd2) ? 2'd0 : ck_q + 2'd1;
                    cj_d    = (ck_q != 2'd2) ? cj_q : (cj_q == 2'd2) ? 2'd0 : cj_q + 2'd1;
                    ci_d    = (ck_q == 2'd2 && cj_q == 2'd2) ? ci_q + 2'd1 : ci_q;
                    drain_d = ci_q == 2'd2 && cj_q == 2'd2 && ck_q == 2'd2;
                end
                if (mac_v)
                    p_d[wi_q][wj_q] = mac_res;
                if (drain_q)
                    state_d = CHECK;
            end
            CHECK: begin
                pass_d  = all_ok;
                state_d = DONE;
`ifdef INV_CHECK_MAXERR_EN
                maxerr_d = (merr > MAXE) ? MAXE[DW-1:0] : merr[DW-1:0];
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            ai_q    <= '0;
            p_q     <= '0;
            pass_q  <= 1'b0;
            ovr_q   <= 1'b0;
            drain_q <= 1'b0;
            ci_q    <= 2'd0;
            cj_q    <= 2'd0;
            ck_q    <= 2'd0;
            wi_q    <= 2'd0;
            wj_q    <= 2'd0;
`ifdef INV_CHECK_MAXERR_EN
            maxerr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            ai_q    <= ai_d;
            p_q     <= p_d;
            pass_q  <= pass_d;
            ovr_q   <= ovr_d;
            drain_q <= drain_d;
            ci_q    <= ci_d;
            cj_q    <= cj_d;
            ck_q    <= ck_d;
            wi_q    <= wi_d;
            wj_q    <= wj_d;
`ifdef INV_CHECK_MAXERR_EN
            maxerr_q <= maxerr_d;
`endif
        end
    end
    assign bus.P       = p_q;
    assign bus.pass    = pass_q;
    assign bus.done    = state_q == DONE;
    assign bus.busy    = busy;
    assign bus.overrun = ovr_q;
`ifdef INV_CHECK_MAXERR_EN
    assign bus.max_err = maxerr_q;
`endif
endmodule

// File: tb/tb_inv_check_mac.sv
// tb_inv_check_mac: directed and random runs of inv_check_mac against a fixed-point matrix product model
module tb_inv_check_mac;
    import inv_check_pkg::*;
    localparam int DW   = DW_DEF;
    localparam int FRAC = FRAC_DEF;
    localparam int TOL  = 655;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    bit ovr_exp = 1'b0;
    inv_check_mac_if #(.DW(DW)) bus ();
    inv_check_mac #(.DW(DW), .FRAC(FRAC), .TOL(TOL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic mat3_t diag(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        mat3_t r;
        r = '0;
        r[0][0] = x;
        r[1][1] = y;
        r[2][2] = z;
        return r;
    endfunction
    function automatic mat3_t model_p(input mat3_t x, input mat3_t y);
        mat3_t r;
        logic signed [95:0] s;
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++) begin
                s = '0;
                for (int k = 0; k < 3; k++)
                    s += 96'($signed(x[m][k])) * 96'($signed(y[k][n]));
                s = s >>> FRAC;
                r[m][n] = (s > 96'sd2147483647) ? 32'h7FFFFFFF :
                          (s < -96'sd2147483648) ? 32'h80000000 : s[31:0];
            end
        return r;
    endfunction
    function automatic bit model_pass(input mat3_t p);
        longint err;
        bit ok;
        ok = 1'b1;
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++) begin
                err = longint'($signed(p[m][n])) - ((m == n) ? longint'(ONE) : 0);
                if (err < 0) err = -err;
                if (err > TOL) ok = 1'b0;
            end
        return ok;
    endfunction
    task automatic drive_a(input mat3_t m);
        bus.a = m[0][0]; bus.b = m[0][1]; bus.c = m[0][2];
        bus.d = m[1][0]; bus.e = m[1][1]; bus.f = m[1][2];
        bus.g = m[2][0]; bus.h = m[2][1]; bus.i = m[2][2];
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_P"}, 64'(|bus.P), 64'd0);
        chk({tag, "_pass"}, 64'(bus.pass), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_ovr"}, 64'(bus.overrun), 64'd0);
    endtask
    task automatic run(input string tag, input mat3_t am, input mat3_t im,
                       input bit sep, input int glitch_at, input int rst_at);
        mat3_t ep, junk;
        bit epass;
        int n;
        ep = model_p(am, im);
        epass = model_pass(ep);
        for (int m = 0; m < 3; m++)
            for (int k = 0; k < 3; k++)
                junk[m][k] = 32'h7FFF0000;
        @(negedge clk);
        drive_a(am);
        bus.a_valid = 1'b1;
        if (sep) begin
            @(posedge clk);
            @(negedge clk);
            bus.a_valid = 1'b0;
            drive_a(junk);
        end
        bus.A_inv = im;
        bus.inv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.a_valid = 1'b0;
        bus.inv_valid = 1'b0;
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        chk({tag, "_passclr"}, 64'(bus.pass), 64'd0);
        n = 0;
        while (!bus.done && n < 40) begin
            if (n + 1 == glitch_at) begin
                drive_a(junk);
                bus.A_inv = junk;
                bus.a_valid = 1'b1;
                bus.inv_valid = 1'b1;
                ovr_exp = 1'b1;
            end
            if (n + 1 == rst_at) begin
                rst_n = 1'b0;
                #1;
                ovr_exp = 1'b0;
                chk_zero({tag, "_rst"});
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            bus.a_valid = 1'b0;
            bus.inv_valid = 1'b0;
        end
        chk({tag, "_latency"}, 64'(n), 64'd29);
        for (int m = 0; m < 3; m++)
            for (int k = 0; k < 3; k++)
                chk($sformatf("%s_P%0d%0d", tag, m, k), 64'(bus.P[m][k]), 64'(ep[m][k]));
        chk({tag, "_pass"}, 64'(bus.pass), 64'(epass));
        chk({tag, "_ovr"}, 64'(bus.overrun), 64'(ovr_exp));
        repeat (2) @(negedge clk);
        chk({tag, "_done1"}, 64'(bus.done), 64'd0);
        chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
        chk({tag, "_hold"}, 64'(bus.P[2][2]), 64'(ep[2][2]));
        chk({tag, "_holdpass"}, 64'(bus.pass), 64'(epass));
    endtask
    initial begin
        mat3_t id, m1, m2;
        bus.a_valid = 1'b0;
        bus.inv_valid = 1'b0;
        bus.A_inv = '0;
        drive_a('0);
        id = diag(ONE, ONE, ONE);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        run("ident", id, id, 1'b0, 0, 0);
        run("diag", diag(32'h00020000, 32'h00040000, 32'h00080000),
            diag(32'h00008000, 32'h00004000, 32'h00002000), 1'b0, 0, 0);
        chk("diag_pass_const", 64'(bus.pass), 64'd1);
        m1 = id;
        m1[0][1] = 32'h00020000;
        run("rowop", m1, id, 1'b0, 0, 0);
        chk("rowop_p01_const", 64'(bus.P[0][1]), 64'h00020000);
        for (int m = 0; m < 3; m++)
            for (int k = 0; k < 3; k++)
                m2[m][k] = 32'h7FFF0000;
        run("sat", m2, m2, 1'b0, 0, 0);
        chk("sat_p11_const", 64'(bus.P[1][1]), 64'h7FFFFFFF);
        m1 = id; m1[1][2] = 32'd655;
        run("tol_in", id, m1, 1'b1, 0, 0);
        m1 = id; m1[1][2] = 32'd656;
        run("tol_out", id, m1, 1'b0, 0, 0);
        m1 = id; m1[2][2] = ONE - 32'd655;
        run("tol_dlo", id, m1, 1'b1, 0, 0);
        m1 = id; m1[0][0] = ONE + 32'd656;
        run("tol_dhi", id, m1, 1'b0, 0, 0);
        for (int t = 0; t < 4; t++) begin
            for (int m = 0; m < 3; m++)
                for (int k = 0; k < 3; k++) begin
                    m1[m][k] = 32'($urandom_range(0, 1 << 20)) - 32'(1 << 19);
                    m2[m][k] = 32'($urandom_range(0, 1 << 20)) - 32'(1 << 19);
                end
            run($sformatf("rnd%0d", t), m1, m2, t[0], 0, 0);
        end
        for (int t = 0; t < 4; t++) begin
            for (int m = 0; m < 3; m++)
                for (int k = 0; k < 3; k++)
                    m2[m][k] = id[m][k] + 32'($urandom_range(0, 1600)) - 32'd800;
            run($sformatf("near%0d", t), id, m2, 1'b0, 0, 0);
        end
        run("ovr", id, id, 1'b0, 5, 0);
        run("rst", diag(32'h00020000, 32'h00040000, 32'h00080000), id, 1'b0, 0, 10);
        run("post_rst", id, id, 1'b0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inv_check_mac.md
INV_CHECK_MAC -- requirements
Module: inv_check_mac

Interface
REQ-001 SHALL have parameter DW, default 32: data word width, signed two's complement.
REQ-002 SHALL have parameter FRAC, default 16: fractional bits (Q16.16 fixed point).
REQ-003 SHALL have parameter TOL, default 655: absolute tolerance in LSBs (about 0.01).
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports a, b, c, d, e, f, g, h, i, input, DW each: the original matrix A in row-major order.
REQ-007 SHALL have port a_valid, input, 1 bit: capture strobe for a..i.
REQ-008 SHALL have port A_inv[2:0][2:0], input, DW each: the inverse under test.
REQ-009 SHALL have port inv_valid, input, 1 bit: capture strobe for A_inv that also starts the check.
REQ-010 SHALL have port P[2:0][2:0], output, DW each: the product A x A_inv.
REQ-011 SHALL have ports pass, done, busy and overrun, output, 1 bit each.

Function
REQ-012 SHALL capture a..i on any clk edge where a_valid=1 and busy=0.
REQ-013 SHALL, in state IDLE with inv_valid=1, capture A_inv and go to state MAC on that edge.
REQ-014 SHALL, when a_valid and inv_valid are high on the same edge in IDLE, capture both and compute with the newly captured A.
REQ-015 SHALL use states IDLE -> MAC -> CHECK -> DONE -> IDLE; no other transitions except reset.
REQ-016 SHALL, in MAC, compute one signed DW x DW product per cycle: 27 cycles, k innermost, then j, then i.
REQ-017 SHALL accumulate each element in 2*DW+2 bits and arithmetic-shift right by FRAC, truncating toward minus infinity.
REQ-018 SHALL saturate each shifted element to [-2^(DW-1), 2^(DW-1)-1] and write it to P[i][j] when its k=2 term completes.
REQ-019 SHALL, in CHECK (1 cycle), set pass=1 only if |P[i][j] - I[i][j]| <= TOL for all nine elements, where I diagonal = 1<<FRAC and off-diagonal = 0.
REQ-020 SHALL hold done=1 in DONE for exactly one cycle, 29 edges after the capturing inv_valid edge.
REQ-021 SHALL hold busy=1 from the edge after capture through DONE inclusive.
REQ-022 SHALL hold P and pass stable from DONE until the next capture; pass SHALL clear on capture.
REQ-023 SHALL ignore inv_valid or a_valid while busy=1 and set sticky overrun=1.
REQ-024 SHALL clear overrun only on reset.

Reset
REQ-025 SHALL, on rst_n=0 (asynchronous), force state IDLE and P, pass, done, busy, overrun, captured A and captured A_inv to zero.
REQ-026 SHALL, on reset mid-MAC, abandon the computation; the first run after release SHALL behave as from power-up.

Configuration
REQ-027 SHALL, with INV_CHECK_MAXERR_EN defined, add output max_err, DW bits: the largest |P - I| element of the last run, updated in CHECK, reset to 0, saturated to 2^(DW-1)-1.
REQ-028 SHALL, without INV_CHECK_MAXERR_EN, omit the max_err port and its logic; all other behaviour is unchanged.

Structure
REQ-029 SHALL take DW/FRAC defaults, ONE=1<<FRAC, the state enum and a 3x3 matrix typedef from shared package inv_check_pkg.
REQ-030 SHALL implement multiply, accumulate, shift and saturate in sub-module fx_mac, instantiated once.

Verification
REQ-031 SHALL verify: A = identity, A_inv = identity (0x00010000 diagonal) -> P = identity, pass=1, done exactly 29 edges after inv_valid.
REQ-032 SHALL verify: A = diag(2,4,8), A_inv = diag(0.5,0.25,0.125) = 0x8000/0x4000/0x2000 -> P = identity, pass=1.
REQ-033 SHALL verify: A = [[1,2,0],[0,1,0],[0,0,1]], A_inv = identity -> P[0][1] = 0x00020000, pass=0.
REQ-034 SHALL verify: A all 0x7FFF0000, A_inv all 0x7FFF0000 -> every P element = 0x7FFFFFFF, pass=0.
REQ-035 SHALL verify: a second inv_valid at MAC cycle 5 -> ignored, overrun=1, first result unchanged and still completes at +29.
REQ-036 SHALL verify: rst_n pulsed low at MAC cycle 10 -> all outputs 0 immediately; the next identity run passes.
